// File: rtl/regs_scoreboard.sv
// Register file with two write ports, NUM_RD combinational read ports with
// write-through bypass, and a per-register busy scoreboard with a registered
// population count of the pending registers.
module regs_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wen0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       wen1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [DATA_W-1:0] regs_d [Depth];
    logic [Depth-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    // Effective enables: r0 is hardwired and nothing is accepted during reset.
    logic we0, we1, iss;
    assign we0 = wen0 & ~rst & (waddr0 != '0);
    assign we1 = wen1 & ~rst & (waddr1 != '0);
    assign iss = issue_en & ~rst & (issue_addr != '0);

    // Next register contents; port 1 is applied last so it wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (we0) regs_d[waddr0] = wdata0;
        if (we1) regs_d[waddr1] = wdata1;
    end

    // Next busy bits; the issue set is applied after the write clears.
    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[waddr0] = 1'b0;
        if (we1) busy_d[waddr1] = 1'b0;
        if (iss) busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Population count of the current busy bits, registered on the next edge.
    always_comb begin
        cnt_d = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            cnt_d = cnt_d + (ADDR_W + 1)'(busy_q[i]);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_cnt = cnt_q;

    // Combinational reads with bypass; a same-cycle write also hides busy.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (raddr[k*ADDR_W +: ADDR_W] != '0) begin
                rdata[k*DATA_W +: DATA_W] = regs_q[raddr[k*ADDR_W +: ADDR_W]];
                rbusy[k] = busy_q[raddr[k*ADDR_W +: ADDR_W]];
                if (we0 && (waddr0 == raddr[k*ADDR_W +: ADDR_W])) begin
                    rdata[k*DATA_W +: DATA_W] = wdata0;
                    rbusy[k] = 1'b0;
                end
                if (we1 && (waddr1 == raddr[k*ADDR_W +: ADDR_W])) begin
                    rdata[k*DATA_W +: DATA_W] = wdata1;
                    rbusy[k] = 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/regs_scoreboard.md
REGS_SCOREBOARD -- requirements
Module: regs_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth is 2**ADDR_W registers, r0 included.
REQ-003 The block SHALL have parameter NUM_RD, default 3, number of read ports.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have port wen0, input, 1 bit, write enable for write port 0.
REQ-007 The block SHALL have port waddr0, input, ADDR_W bits, write address for port 0.
REQ-008 The block SHALL have port wdata0, input, DATA_W bits, write data for port 0.
REQ-009 The block SHALL have ports wen1, waddr1 and wdata1 with the same directions and widths as port 0, forming write port 1.
REQ-010 The block SHALL have port raddr, input, NUM_RD*ADDR_W bits; read port k uses slice [k*ADDR_W +: ADDR_W].
REQ-011 The block SHALL have port rdata, output, NUM_RD*DATA_W bits; read port k drives slice [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port rbusy, output, NUM_RD bits, pending-write flag for each read address.
REQ-013 The block SHALL have port issue_en, input, 1 bit, marks a destination register as pending.
REQ-014 The block SHALL have port issue_addr, input, ADDR_W bits, the destination register to mark pending.
REQ-015 The block SHALL have port busy_cnt, output, ADDR_W+1 bits, the number of registers currently pending.

Function
REQ-016 r0 SHALL always read 0 and never be busy; writes and issues to address 0 SHALL be ignored.
REQ-017 On the rising clk edge, when wenN=1 and waddrN!=0, the block SHALL load wdataN into register[waddrN].
REQ-018 When both write ports are enabled to the same nonzero address, port 1 SHALL win and the port 0 data SHALL be discarded.
REQ-019 When both write ports are enabled to different addresses, both writes SHALL complete in the same cycle.
REQ-020 Reads SHALL be combinational and take zero cycles of latency.
REQ-021 A read SHALL write-through bypass: if an enabled write in the current cycle targets raddr k (nonzero), rdata k SHALL return that write's wdata, with port 1 taking priority over port 0.
REQ-022 The block SHALL keep one registered busy bit per register.
REQ-023 A rising clk edge with issue_en=1 SHALL set busy[issue_addr].
REQ-024 A rising clk edge with an enabled write SHALL clear busy[waddrN].
REQ-025 When an issue and a write target the same address in the same cycle, the set SHALL win, so busy=1 afterwards (the new producer is still pending).
REQ-026 rbusy[k] SHALL equal busy[raddr k] AND NOT (an enabled write to raddr k in the current cycle), so the combinational clear matches the bypass.
REQ-027 An issue to an address that is already busy SHALL leave it busy; this is not an error.
REQ-028 A write to a non-busy register SHALL still update the data and leave the busy bit at 0.
REQ-029 busy_cnt SHALL be a registered population count of the busy bits, valid one cycle after the edge that changed them, with range 0..2**ADDR_W-1 and no wrap.

Reset
REQ-030 While rst=1, all registers, all busy bits and busy_cnt SHALL be 0 immediately, without waiting for clk.
REQ-031 While rst=1, writes and issues SHALL be ignored.
REQ-032 When rst is asserted mid-operation, all pending state SHALL be discarded.
REQ-033 The first write SHALL be accepted at the first rising clk edge after rst deasserts.
REQ-034 After reset, every rdata SHALL read 0 and every rbusy SHALL read 0.

Verification
REQ-035 The bench SHALL cover: assert rst mid-run with r5=0x1234 and busy[5]=1 -> rdata 0 for raddr=5, rbusy 0 and busy_cnt 0, all without a clk edge.
REQ-036 The bench SHALL cover: wen0 waddr0=3 wdata0=0xAAAA together with wen1 waddr1=3 wdata1=0x5555 -> raddr=3 returns 0x5555 in the same cycle and after the edge.
REQ-037 The bench SHALL cover: wen0 waddr0=7 wdata0=0x11, wen1 waddr1=9 wdata1=0x22 -> next cycle r7=0x11 and r9=0x22.
REQ-038 The bench SHALL cover: issue_en addr=4, then a later write to r4 of 0xBEEF -> rbusy=1 between issue and write, then rbusy=0 and rdata=0xBEEF during the write cycle; busy_cnt goes 1 then 0.
REQ-039 The bench SHALL cover: issue_en addr=6 in the same cycle as a write to r6 -> data updated, busy[6] remains 1 and busy_cnt=1.
REQ-040 The bench SHALL cover: wen0 waddr0=0 wdata0=0xFFFF together with issue_en addr=0 -> rdata for r0 is 0, rbusy 0 and busy_cnt unchanged.
